prefix_subtractor_pipe: RTL and testbench

Pipelined 16-bit unsigned subtractor with borrow-in/borrow-out. It computes minuend − subtrahend − bin through a 4-level parallel-prefix carry network split across two register stages. It is the inverse-operation companion to the combinational 16-bit prefix adder and sits on the datapath behind a valid/ready handshake, so consumers can stall it. Prefix cell function is fixed: p = p_hi & p_lo, g = g_hi | (p_hi & g_lo).

---
 rtl/prefix_subtractor_pipe.sv | 136 +++++++++++++
 tb/tb_prefix_subtractor_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_subtractor_pipe.sv
// Two-stage pipelined 16-bit subtractor: A + ~B + ~bin through a Kogge-Stone
// carry network (distances 1,2 in stage 1; 4,8 in stage 2) behind valid/ready.
module prefix_subtractor_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] minuend,
    input  logic [15:0] subtrahend,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff,
    output logic        bout,
    output logic        zero
);

    logic [15:0] w_nb;
    logic        w_c0;
    logic [15:0] w_p0, w_g0;
    logic [15:0] w_p1, w_g1;
    logic [15:0] w_p2, w_g2;
    logic [15:0] w_p3, w_g3;
    logic [15:0] w_g4;
    logic [15:0] w_carry;
    logic [15:0] w_diff;
    logic        w_adv1, w_adv2;
    logic        w_unused;

    logic [15:0] r_a, r_nb, r_p2, r_g2;
    logic        r_c0, r_s1_valid;
    logic [15:0] r_diff;
    logic        r_bout, r_zero, r_s2_valid;

    assign w_nb = ~subtrahend;
    assign w_c0 = ~bin;

    // Bit 0 absorbs the carry-in, so its group has no propagate term left.
    assign w_p0 = {minuend[15:1] | w_nb[15:1], 1'b0};
    assign w_g0 = {minuend[15:1] & w_nb[15:1],
                   (minuend[0] & w_nb[0]) | ((minuend[0] | w_nb[0]) & w_c0)};

    // Stage 1 prefix levels: distance 1 then 2 (span 4 at every bit).
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lvl1
            if (gi >= 1) begin : g_comb
                assign w_p1[gi] = w_p0[gi] & w_p0[gi-1];
                assign w_g1[gi] = w_g0[gi] | (w_p0[gi] & w_g0[gi-1]);
            end else begin : g_pass
                assign w_p1[gi] = w_p0[gi];
                assign w_g1[gi] = w_g0[gi];
            end
        end
        for (genvar gi = 0; gi < 16; gi++) begin : g_lvl2
            if (gi >= 2) begin : g_comb
                assign w_p2[gi] = w_p1[gi] & w_p1[gi-2];
                assign w_g2[gi] = w_g1[gi] | (w_p1[gi] & w_g1[gi-2]);
            end else begin : g_pass
                assign w_p2[gi] = w_p1[gi];
                assign w_g2[gi] = w_g1[gi];
            end
        end
    endgenerate

    // Stage 2 prefix levels: distance 4 then 8 from the registered groups.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lvl3
            if (gi >= 4) begin : g_comb
                assign w_p3[gi] = r_p2[gi] & r_p2[gi-4];
                assign w_g3[gi] = r_g2[gi] | (r_p2[gi] & r_g2[gi-4]);
            end else begin : g_pass
                assign w_p3[gi] = r_p2[gi];
                assign w_g3[gi] = r_g2[gi];
            end
        end
        for (genvar gi = 0; gi < 16; gi++) begin : g_lvl4
            if (gi >= 8) begin : g_comb
                assign w_g4[gi] = w_g3[gi] | (w_p3[gi] & w_g3[gi-8]);
            end else begin : g_pass
                assign w_g4[gi] = w_g3[gi];
            end
        end
    endgenerate

    // Low-half propagates are already folded into their generates.
    assign w_unused = ^w_p3[7:0];

    assign w_carry = {w_g4[14:0], r_c0};
    assign w_diff  = r_a ^ r_nb ^ w_carry;

    assign w_adv2   = !r_s2_valid | out_ready;
    assign w_adv1   = !r_s1_valid | w_adv2;
    assign in_ready = w_adv1 & !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_nb       <= '0;
            r_p2       <= '0;
            r_g2       <= '0;
            r_c0       <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_a  <= minuend;
                r_nb <= w_nb;
                r_p2 <= w_p2;
                r_g2 <= w_g2;
                r_c0 <= w_c0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_bout     <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff <= w_diff;
                r_bout <= ~w_g4[15];
                r_zero <= (w_diff == 16'h0000);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign zero      = r_zero;

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Bench for prefix_subtractor_pipe: queue-based scoreboard with a 17-bit
// arithmetic model, directed corner cases and random valid/ready traffic.
module tb_prefix_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] minuend;
    logic [15:0] subtrahend;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        zero;

    typedef struct packed {
        int          tag;
        logic [16:0] r;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cur   = 0;
    int   n_out = 0;
    bit   started = 1'b0;
    bit   prev_rst = 1'b1;

    always #5 clk = ~clk;

    prefix_subtractor_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .bout       (bout),
        .zero       (zero)
    );

    // {bout, diff}: bit 16 of the 17-bit difference is set iff A < B + bin.
    function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                            input logic bi);
        return {1'b0, a} - {1'b0, b} - {16'h0000, bi};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: sampled on the falling edge, updated for the upcoming rising edge.
    always @(negedge clk) begin
        if (started) begin
            logic exp_v;
            logic exp_rdy;
            exp_v   = (q.size() > 0) && (q[0].tag + 2 <= cur);
            exp_rdy = !rst && ((q.size() < 2) || out_ready);
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            if (out_valid && exp_v) begin
                check("diff", {16'b0, diff}, {16'b0, q[0].r[15:0]});
                check("bout", {31'b0, bout}, {31'b0, q[0].r[16]});
                check("zero", {31'b0, zero}, {31'b0, (q[0].r[15:0] == 16'h0000)});
                $display("beat out: diff=%04h bout=%0b zero=%0b", diff, bout, zero);
            end
            if (prev_rst) begin
                check("rst_diff", {16'b0, diff}, 32'h0);
                check("rst_bout", {31'b0, bout}, 32'h0);
                check("rst_zero", {31'b0, zero}, 32'h0);
            end
            if (rst) begin
                q.delete();
            end else begin
                if (exp_v && out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
                if (in_valid && exp_rdy)
                    q.push_back('{tag: cur, r: ref_sub(minuend, subtrahend, bin)});
            end
            prev_rst = rst;
            cur++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [15:0] a, input logic [15:0] b, input logic bi);
        in_valid   = 1'b1;
        minuend    = a;
        subtrahend = b;
        bin        = bi;
    endtask

    task automatic send_check(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic bi, input logic [15:0] ed, input logic eb,
                              input logic ez);
        set_beat(a, b, bi);
        step();
        in_valid = 1'b0;
        step();
        check({name, "_valid"}, {31'b0, out_valid}, 32'h1);
        check({name, "_diff"}, {16'b0, diff}, {16'b0, ed});
        check({name, "_bout"}, {31'b0, bout}, {31'b0, eb});
        check({name, "_zero"}, {31'b0, zero}, {31'b0, ez});
        step();
    endtask

    initial begin
        int          acc;
        int          base;
        logic        was;
        logic [15:0] d0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        minuend = '0; subtrahend = '0; bin = 1'b0;
        @(posedge clk);
        started = 1'b1;
        #1;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", {31'b0, in_ready}, 32'h1);
        step();

        // Hand-computed values pinning the reference model itself.
        check("model_basic", {15'b0, ref_sub(16'h1234, 16'h0234, 1'b0)}, 32'h01000);
        check("model_wrap", {15'b0, ref_sub(16'h0000, 16'h0001, 1'b0)}, 32'h1FFFF);
        check("model_bin", {15'b0, ref_sub(16'h0000, 16'h0000, 1'b1)}, 32'h1FFFF);
        check("model_zero", {15'b0, ref_sub(16'h8000, 16'h7FFF, 1'b1)}, 32'h00000);

        send_check("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        send_check("wrap", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        send_check("zero", 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);
        send_check("fullbor", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        send_check("equal", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1);

        // Backpressure: two beats fill the pipe, the rest wait for out_ready.
        base = n_out;
        acc = 0;
        out_ready = 1'b0;
        set_beat(16'(acc * 16'h1111 + 16'h0100), 16'(acc), 1'b0);
        for (int k = 0; k < 20 && acc < 2; k++) begin
            @(negedge clk);
            was = in_ready;
            step();
            if (was) begin
                acc++;
                set_beat(16'(acc * 16'h1111 + 16'h0100), 16'(acc), 1'b0);
            end
        end
        @(negedge clk);
        check("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
        d0 = diff;
        repeat (3) step();
        @(negedge clk);
        check("bp_diff_stable", {16'b0, diff}, {16'b0, d0});
        check("bp_valid_held", {31'b0, out_valid}, 32'h1);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && acc < 5; k++) begin
            @(negedge clk);
            was = in_ready;
            step();
            if (was) begin
                acc++;
                set_beat(16'(acc * 16'h1111 + 16'h0100), 16'(acc), 1'b0);
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && (n_out - base) < 5; k++) step();
        check("bp_results", n_out - base, 5);

        // Reset with both stages full: nothing in flight may ever appear.
        out_ready = 1'b0;
        set_beat(16'hAAAA, 16'h5555, 1'b0);
        step();
        set_beat(16'h0F0F, 16'hF0F0, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_full", {31'b0, out_valid}, 32'h1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rdy_in_rst", {31'b0, in_ready}, 32'h0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_flushed", {31'b0, out_valid}, 32'h0);
        check("mid_rdy_release", {31'b0, in_ready}, 32'h1);
        repeat (3) step();

        // Random traffic with random stalls on both sides.
        for (int k = 0; k < 10000; k++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            minuend    = 16'($urandom);
            subtrahend = 16'($urandom);
            bin        = 1'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        check("final_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
